// File: rtl/uart_rx.sv
// UART serial receiver: 2-flop synchroniser, frame FSM, read-data/status outputs for the CSR block.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each nominal sample cycle.
module uart_rx #(
  parameter int DATA_WIDTH    = 32,
  parameter int MIN_DATA_BITS = 5,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic [DATA_WIDTH-1:0] baud_rate_i,
  input  logic [3:0]            data_bits_i,
  input  logic                  parity_en_i,
  input  logic                  odd_parity_i,
  input  logic                  read_ack_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  parity_error_o,
  output logic                  data_bits_error_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  localparam logic [3:0]            MIN_DB   = 4'(MIN_DATA_BITS);
  localparam logic [3:0]            MAX_DB   = 4'(MAX_DATA_BITS);
  localparam logic [DATA_WIDTH-1:0] MIN_P    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  state_e                   state_q, state_d;
  logic                     sync1_q, sync2_q, prev_q;
  logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    period_q, period_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     pe_q, pe_d, odd_q, odd_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     frame_perr_q, frame_perr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d, perr_q, perr_d;

  logic                     sample;
  logic [DATA_WIDTH-1:0]    period_eff;
  logic [DATA_WIDTH-1:0]    start_load;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is the line one cycle ago, hist_q[1] two cycles ago; decision lands at nominal +1
  logic [1:0] hist_q;
  assign sample     = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
  assign start_load = period_eff >> 1;
`else
  assign sample     = sync2_q;
  assign start_load = (period_eff >> 1) - ONE;
`endif

  assign period_eff        = (baud_rate_i < MIN_P) ? MIN_P : baud_rate_i;
  assign data_bits_error_o = (data_bits_i < MIN_DB) || (data_bits_i > MAX_DB);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    nbits_d      = nbits_q;
    pe_d         = pe_q;
    odd_d        = odd_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    frame_perr_d = frame_perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    perr_d       = perr_q;

    if (read_ack_i) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!data_bits_error_o && prev_q && !sync2_q) begin
          state_d      = S_START;
          cnt_d        = start_load;
          period_d     = period_eff;
          nbits_d      = data_bits_i;
          pe_d         = parity_en_i;
          odd_d        = odd_parity_i;
          bit_cnt_d    = 4'd0;
          shreg_d      = '0;
          frame_perr_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else if (!sample) begin
          state_d   = S_DATA;
          cnt_d     = period_q - ONE;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else begin
          shreg_d[bit_cnt_q] = sample;
          cnt_d              = period_q - ONE;
          if (bit_cnt_q == nbits_q - 4'd1) state_d = pe_q ? S_PARITY : S_STOP;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else begin
          frame_perr_d = sample ^ (^shreg_q) ^ odd_q;
          cnt_d        = period_q - ONE;
          state_d      = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else if (sample) begin
          // completion overrides a same-cycle read_ack and overwrites any unread word
          data_d  = DATA_WIDTH'(shreg_q);
          valid_d = 1'b1;
          perr_d  = pe_q & frame_perr_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      period_q     <= MIN_P;
      nbits_q      <= MIN_DB;
      pe_q         <= 1'b0;
      odd_q        <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= '0;
      frame_perr_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      nbits_q      <= nbits_d;
      pe_q         <= pe_d;
      odd_q        <= odd_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      frame_perr_q <= frame_perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], sync2_q};
  end
`endif

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign parity_error_o = perr_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;
  localparam int DW = 32;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] baud = 32'd16;
  logic [3:0]    dbits = 4'd8;
  logic          pe = 1'b1, odd = 1'b1, ack = 1'b0;
  logic [DW-1:0] data_o;
  logic          data_valid_o, parity_error_o, data_bits_error_o, busy_o;

  uart_rx #(.DATA_WIDTH(DW), .MIN_DATA_BITS(5), .MAX_DATA_BITS(9)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .baud_rate_i(baud), .data_bits_i(dbits),
    .parity_en_i(pe), .odd_parity_i(odd), .read_ack_i(ack), .data_o(data_o),
    .data_valid_o(data_valid_o), .parity_error_o(parity_error_o),
    .data_bits_error_o(data_bits_error_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] m_data = '0;
  bit m_valid = 0, m_perr = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic int eff_p(input logic [DW-1:0] b);
    return (b < 4) ? 4 : int'(b);
  endfunction

  // Drives one frame one clock at a time; cycle c is driven at the negedge ahead of posedge c+1.
  task automatic send(input logic [15:0] d, input int n, input bit par_on, input bit pbit,
                      input bit stop, input int glitch_c, input int ack_c, input int rst_c,
                      output bit saw_busy, output bit busy_end);
    int  p   = eff_p(baud);
    int  nb  = 2 + n + (par_on ? 1 : 0);
    int  tot = p * nb + (stop ? 0 : p + 8);
    bit  bits[16];
    bit  v;
    bit  aborted = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < n; i++) bits[1+i] = d[i];
    if (par_on) bits[1+n] = pbit;
    bits[nb-1] = stop;
    saw_busy = 0;
    busy_end = 0;
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      if (busy_o) saw_busy = 1;
      if (c == rst_c) begin
        rst_n   = 1'b0;
        aborted = 1;
        break;
      end
      v = (c < p * nb) ? bits[c / p] : 1'b0;
      if (c == glitch_c) v = ~v;
      rx  = v;
      ack = (c == ack_c);
    end
    if (!aborted) begin
      @(negedge clk);
      busy_end = busy_o;
      ack = 1'b0;
      rx  = 1'b1;
      repeat (p + 12) @(negedge clk);
    end
  endtask

  task automatic frame(input string tag, input logic [15:0] d, input int n, input bit par_on,
                       input bit pbit, input bit stop, input int glitch_c, input int ack_c);
    bit saw, bend, legal;
    legal = (n >= 5) && (n <= 9);
    send(d, n, par_on, pbit, stop, glitch_c, ack_c, -1, saw, bend);
    if (legal && stop) begin
      m_data  = DW'(d);
      m_valid = 1;
      m_perr  = par_on && (pbit != ((^d) ^ odd));
    end
    check({tag, ".data"}, data_o, m_data);
    check({tag, ".valid"}, DW'(data_valid_o), DW'(m_valid));
    check({tag, ".perr"}, DW'(parity_error_o), DW'(m_perr));
    check({tag, ".busy_idle"}, DW'(busy_o), 0);
    check({tag, ".saw_busy"}, DW'(saw), DW'(legal));
    if (legal && !stop) check({tag, ".busy_held"}, DW'(bend), 1);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    m_valid = 0;
    m_perr  = 0;
    check({tag, ".valid"}, DW'(data_valid_o), 0);
    check({tag, ".perr"}, DW'(parity_error_o), 0);
    check({tag, ".data"}, data_o, m_data);
  endtask

  initial begin
    bit saw, bend;
    repeat (3) @(negedge clk);
    check("rst.data", data_o, 0);
    check("rst.valid", DW'(data_valid_o), 0);
    check("rst.perr", DW'(parity_error_o), 0);
    check("rst.dbe", DW'(data_bits_error_o), 0);
    check("rst.busy", DW'(busy_o), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame("t1", 16'hA5, 8, 1, 1, 1, -1, -1);
    frame("t2", 16'hA5, 8, 1, 0, 1, -1, -1);
    check("t2.perr_set", DW'(parity_error_o), 1);
    do_ack("t2ack");

    saw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rx = (c < 3) ? 1'b0 : 1'b1;
      if (busy_o) saw = 1;
    end
    check("t3.saw_busy", DW'(saw), 1);
    check("t3.busy", DW'(busy_o), 0);
    check("t3.valid", DW'(data_valid_o), 0);

    dbits = 4'd4;
    #1 check("t4.dbe4", DW'(data_bits_error_o), 1);
    frame("t4f", 16'h0B, 4, 1, 0, 1, -1, -1);
    dbits = 4'd10;
    #1 check("t4.dbe10", DW'(data_bits_error_o), 1);
    frame("t4g", 16'h155, 10, 1, 0, 1, -1, -1);
    dbits = 4'd9;
    #1 check("t4.dbe9", DW'(data_bits_error_o), 0);
    dbits = 4'd5;
    #1 check("t4.dbe5", DW'(data_bits_error_o), 0);

    pe = 1'b0;
    frame("t5a", 16'h15, 5, 0, 0, 1, -1, -1);
    frame("t5b", 16'h0A, 5, 0, 0, 1, -1, 8 + 3 + 16 * 6 + MAJ - 1);
    frame("t5c", 16'h03, 5, 0, 0, 0, -1, -1);
    check("t5.data_kept", data_o, 32'h0A);

    dbits = 4'd8;
    frame("t6a", 16'h5A, 8, 0, 0, 1, -1, -1);
    send(16'hC3, 8, 0, 0, 1, -1, -1, 16 * 4, saw, bend);
    #1;
    check("t6.data", data_o, 0);
    check("t6.valid", DW'(data_valid_o), 0);
    check("t6.perr", DW'(parity_error_o), 0);
    check("t6.busy", DW'(busy_o), 0);
    m_data = '0; m_valid = 0; m_perr = 0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
    frame("t6g", 16'hFF, 8, 0, 0, 1, 8 + 16, -1);
`endif

    for (int it = 0; it < 30; it++) begin
      int n;
      logic [15:0] d;
      bit pb;
      baud  = DW'($urandom_range(0, 20));
      n     = $urandom_range(5, 9);
      dbits = 4'(n);
      pe    = 1'($urandom_range(0, 1));
      odd   = 1'($urandom_range(0, 1));
      d     = 16'($urandom) & 16'((1 << n) - 1);
      pb    = ((^d) ^ odd) ^ ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) do_ack("rnd.ack");
      #1 check("rnd.dbe", DW'(data_bits_error_o), 0);
      frame("rnd", d, n, pe, pb, $urandom_range(0, 4) != 0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
